mux_serializer: RTL and testbench

Eight-lane to one-wire time-division serializer, the transmit end feeding an 8-output select-driven demux. On request it snapshots eight 1-bit lanes, then presents them one per accepted beat on a single output with a 3-bit lane index, under a valid/ready handshake. The downstream demux steers each beat to the output selected by `sel`. Frame boundaries are marked for the receiver, with a programmable idle gap between frames.

---
 rtl/mux_serializer.sv | 166 ++++++++++++++++
 tb/tb_mux_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_serializer.sv
// mux_serializer: snapshots eight 1-bit lanes on request and presents them one
// beat at a time on a single wire, with a 3-bit lane index that drives a
// downstream 8-output demux. Beats move under a valid/ready handshake. Frame
// boundaries are marked with frame_start / frame_done, and a programmable idle
// gap follows each frame. Every output comes straight from a register.

module mux_serializer #(
    parameter int unsigned GAP = 2  // idle cycles after the last beat, 0..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       i4,
    input  logic       i5,
    input  logic       i6,
    input  logic       i7,
    input  logic       ready,
    output logic       y,
    output logic [2:0] sel,
    output logic       valid,
    output logic       frame_start,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The counter is loaded with GAP-1 on entry to the gap state. With GAP=0
    // the gap state is never entered and the load value is irrelevant.
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic       GAP_NONE = (GAP == 0) ? 1'b1 : 1'b0;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] shadow_r;
    logic [7:0] shadow_s;
    logic [2:0] sel_r;
    logic [2:0] sel_s;
    logic [2:0] sel_inc_s;
    logic [3:0] gap_cnt_r;
    logic [3:0] gap_cnt_s;
    logic       y_r;
    logic       y_s;
    logic       valid_r;
    logic       valid_s;
    logic       frame_start_r;
    logic       frame_start_s;
    logic       frame_done_r;
    logic       frame_done_s;
    logic [7:0] lanes_s;

    assign lanes_s   = {i7, i6, i5, i4, i3, i2, i1, i0};
    assign sel_inc_s = sel_r + 3'd1;

    // Next-state and next-output decode. Outputs are computed one cycle ahead
    // so they can be registered with no path from ready or en to any pin.
    always_comb begin
        state_s       = state_r;
        shadow_s      = shadow_r;
        sel_s         = sel_r;
        gap_cnt_s     = gap_cnt_r;
        y_s           = y_r;
        valid_s       = valid_r;
        frame_start_s = frame_start_r;
        frame_done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    // Snapshot the lanes; later lane changes cannot reach this frame.
                    state_s       = ST_SEND;
                    shadow_s      = lanes_s;
                    sel_s         = 3'd0;
                    y_s           = lanes_s[0];
                    valid_s       = 1'b1;
                    frame_start_s = 1'b1;
                end else begin
                    state_s       = ST_IDLE;
                    valid_s       = 1'b0;
                    frame_start_s = 1'b0;
                end
            end

            ST_SEND: begin
                if (ready) begin
                    if (sel_r == 3'd7) begin
                        // Last beat accepted: close the frame. sel and y keep
                        // their beat-7 values until the next load.
                        frame_done_s  = 1'b1;
                        valid_s       = 1'b0;
                        frame_start_s = 1'b0;
                        if (GAP_NONE) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s   = ST_GAP;
                            gap_cnt_s = GAP_LOAD;
                        end
                    end else begin
                        sel_s         = sel_inc_s;
                        y_s           = shadow_r[sel_inc_s];
                        frame_start_s = 1'b0;
                    end
                end else begin
                    // Backpressure: the presented beat is held unchanged.
                    state_s = ST_SEND;
                    valid_s = 1'b1;
                end
            end

            ST_GAP: begin
                valid_s       = 1'b0;
                frame_start_s = 1'b0;
                if (gap_cnt_r == 4'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end

            default: begin
                state_s       = ST_IDLE;
                valid_s       = 1'b0;
                frame_start_s = 1'b0;
                gap_cnt_s     = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-frame
    // drops the partial frame without a frame_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            shadow_r      <= 8'd0;
            sel_r         <= 3'd0;
            gap_cnt_r     <= 4'd0;
            y_r           <= 1'b0;
            valid_r       <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            shadow_r      <= shadow_s;
            sel_r         <= sel_s;
            gap_cnt_r     <= gap_cnt_s;
            y_r           <= y_s;
            valid_r       <= valid_s;
            frame_start_r <= frame_start_s;
            frame_done_r  <= frame_done_s;
        end
    end

    assign y           = y_r;
    assign sel         = sel_r;
    assign valid       = valid_r;
    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_mux_serializer.sv
// Testbench for mux_serializer: two instances (GAP=0 and GAP=2) share one
// stimulus stream; each is compared every cycle against a frame-level model,
// and directed sequences exercise the timing corners.

module tb_mux_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       ready;
    logic [7:0] lanes;

    logic       y2, v2, fs2, fd2;
    logic [2:0] s2;
    logic       y0, v0, fs0, fd0;
    logic [2:0] s0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Clock generation
    always #5 clk = ~clk;

    mux_serializer #(.GAP(2)) u_g2 (
        .clk(clk), .reset(reset), .en(en),
        .i0(lanes[0]), .i1(lanes[1]), .i2(lanes[2]), .i3(lanes[3]),
        .i4(lanes[4]), .i5(lanes[5]), .i6(lanes[6]), .i7(lanes[7]),
        .ready(ready), .y(y2), .sel(s2), .valid(v2),
        .frame_start(fs2), .frame_done(fd2)
    );

    mux_serializer #(.GAP(0)) u_g0 (
        .clk(clk), .reset(reset), .en(en),
        .i0(lanes[0]), .i1(lanes[1]), .i2(lanes[2]), .i3(lanes[3]),
        .i4(lanes[4]), .i5(lanes[5]), .i6(lanes[6]), .i7(lanes[7]),
        .ready(ready), .y(y0), .sel(s0), .valid(v0),
        .frame_start(fs0), .frame_done(fd0)
    );

    // Reference model: index 0 is the GAP=0 instance, index 1 the GAP=2 one.
    // A frame is a captured byte plus a count of beats still to deliver.
    logic [7:0] m_frame [2];
    int         m_left  [2];
    int         m_gap   [2];
    bit         m_done  [2];
    logic [2:0] m_lsel  [2];
    logic       m_ly    [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int gap);
        bit done_n;
        if (reset) begin
            m_left[k] = 0; m_gap[k] = 0; m_done[k] = 1'b0;
            m_lsel[k] = 3'd0; m_ly[k] = 1'b0; m_frame[k] = 8'd0;
        end else begin
            done_n = 1'b0;
            if (m_left[k] > 0) begin
                if (ready) begin
                    m_ly[k]   = m_frame[k][8 - m_left[k]];
                    m_lsel[k] = 3'(8 - m_left[k]);
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        done_n   = 1'b1;
                        m_gap[k] = gap;
                    end
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k] = m_gap[k] - 1;
            end else if (en) begin
                m_frame[k] = lanes;
                m_left[k]  = 8;
            end
            m_done[k] = done_n;
        end
    endtask

    function automatic logic [6:0] model_exp(input int k);
        logic       v;
        logic [2:0] s;
        logic       yy;
        v = (m_left[k] > 0);
        if (v) begin
            s  = 3'(8 - m_left[k]);
            yy = m_frame[k][8 - m_left[k]];
        end else begin
            s  = m_lsel[k];
            yy = m_ly[k];
        end
        return {v, s, yy, (m_left[k] == 8), m_done[k]};
    endfunction

    // Advance the model on the same edge the DUTs sample their inputs
    always @(posedge clk) begin
        model_step(0, 0);
        model_step(1, 2);
    end

    // Scoreboard comparison away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("sb_gap0", {25'd0, v0, s0, y0, fs0, fd0}, {25'd0, model_exp(0)});
            check("sb_gap2", {25'd0, v2, s2, y2, fs2, fd2}, {25'd0, model_exp(1)});
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] lanes;   // {i7..i0}
        logic [7:0] beats;   // MSB = beat 0 ... LSB = beat 7
    } vec_t;

    vec_t tbl [6];

    task automatic idle(input int n);
        en = 1'b0;
        ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One frame on the GAP=2 instance with ready high; lanes flip to FF after load.
    task automatic run_frame(input logic [7:0] l, output logic [7:0] seq);
        lanes = l; en = 1'b1; ready = 1'b1;
        @(negedge clk);
        en = 1'b0; lanes = 8'hFF;
        seq = 8'd0;
        for (int k = 0; k < 8; k++) begin
            check("beat_valid", v2, 1);
            check("beat_sel", s2, k);
            check("beat_fs", fs2, (k == 0));
            check("beat_fd", fd2, 0);
            seq[7 - k] = y2;
            @(negedge clk);
        end
        check("done_pulse", fd2, 1);
        check("gap1_valid", v2, 0);
        check("gap1_sel", s2, 7);
        @(negedge clk);
        check("done_once", fd2, 0);
        check("gap2_valid", v2, 0);
        @(negedge clk);
        check("idle_valid", v2, 0);
    endtask

    initial begin
        logic [7:0] seq;
        int vcnt, s4cnt, stall, fsn, fdn, found;
        bit got;

        reset = 1'b1; en = 1'b0; ready = 1'b1; lanes = 8'd0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_valid", v2, 0);
        check("rst_sel", s2, 0);
        check("rst_y", y2, 0);
        check("rst_fs", fs2, 0);
        check("rst_fd", fd2, 0);
        reset = 1'b0;
        idle(4);

        // Table of frames, including the snapshot-isolation pair (lanes go to FF mid-frame)
        tbl[0] = '{8'b1010_0110, 8'b0110_0101};
        tbl[1] = '{8'hFF,        8'hFF};
        tbl[2] = '{8'h00,        8'h00};
        tbl[3] = '{8'h01,        8'b1000_0000};
        tbl[4] = '{8'h80,        8'b0000_0001};
        tbl[5] = '{8'hF0,        8'b0000_1111};
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].lanes, seq);
            check("frame_data", seq, tbl[i].beats);
        end
        idle(4);

        // Backpressure: three stall cycles while sel=4
        lanes = 8'b1010_0110; en = 1'b1; ready = 1'b1;
        @(negedge clk);
        en = 1'b0; lanes = 8'hFF;
        vcnt = 0; s4cnt = 0; stall = 3; seq = 8'd0; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (fd2 === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (v2 === 1'b1) begin
                vcnt++;
                seq[7 - int'(s2)] = y2;
                if (s2 == 3'd4) begin
                    s4cnt++;
                    check("bp_y_hold", y2, 0);
                end
            end
            if (v2 === 1'b1 && s2 == 3'd4 && stall > 0) begin
                ready = 1'b0;
                stall--;
            end else begin
                ready = 1'b1;
            end
            @(negedge clk);
        end
        check("bp_done_seen", got, 1);
        check("bp_valid_cycles", vcnt, 11);
        check("bp_sel4_cycles", s4cnt, 4);
        check("bp_data", seq, 8'b0110_0101);
        idle(6);

        // Back-to-back on the GAP=0 instance: 27 cycles, 9-cycle period
        en = 1'b1; ready = 1'b1; lanes = 8'h5A;
        fsn = 0; fdn = 0; vcnt = 0;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            lanes = 8'(c);
            if (fs0 === 1'b1) fsn++;
            if (fd0 === 1'b1) fdn++;
            if (v0 === 1'b1) vcnt++;
            check("b2b_fs_pos", fs0, ((c - 1) % 9 == 0));
            check("b2b_fd_pos", fd0, (c % 9 == 0));
        end
        en = 1'b0;
        check("b2b_starts", fsn, 3);
        check("b2b_dones", fdn, 3);
        check("b2b_valid_cycles", vcnt, 24);
        idle(14);

        // Reset mid-frame at sel=5
        lanes = 8'b1010_0110; en = 1'b1; ready = 1'b1;
        @(negedge clk);
        en = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (v2 === 1'b1 && s2 == 3'd5) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_sel5", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; en = 1'b1;
        check("mrst_valid", v2, 0);
        check("mrst_sel", s2, 0);
        check("mrst_y", y2, 0);
        check("mrst_fd", fd2, 0);
        check("mrst_valid_g0", v0, 0);
        check("mrst_fd_g0", fd0, 0);
        @(negedge clk);
        en = 1'b0;
        check("fresh_valid", v2, 1);
        check("fresh_sel", s2, 0);
        check("fresh_fs", fs2, 1);
        idle(14);

        // en toggled during SEND and GAP must not restart the frame
        lanes = 8'h3C; en = 1'b1; ready = 1'b1;
        @(negedge clk);
        fsn = 0; fdn = 0; vcnt = 0;
        for (int c = 1; c <= 10; c++) begin
            if (fs2 === 1'b1) fsn++;
            if (fd2 === 1'b1) fdn++;
            if (v2 === 1'b1) vcnt++;
            en = ~en;
            @(negedge clk);
        end
        en = 1'b0;
        check("enign_starts", fsn, 1);
        check("enign_dones", fdn, 1);
        check("enign_valid_cycles", vcnt, 8);
        idle(14);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            en    = ($urandom_range(0, 2) != 0);
            ready = ($urandom_range(0, 3) != 0);
            lanes = 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        idle(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
